// File: rtl/btn_events_n_pkg.sv
// rtl/btn_events_n_pkg.sv - shared state encoding and pixel-clock timing constants for button event logic
package btn_events_n_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_LONG    = 2'd2
   } state_t;

   localparam int CLK_PIX_HZ      = 25_000_000;
   localparam int CYCLES_PER_MS   = CLK_PIX_HZ / 1000;

   // Defaults shared with the debounce_n instances on the same buttons.
   localparam int DEF_DEBOUNCE_MS = 10;
   localparam int DEF_LONG_MS     = 500;
   localparam int DEF_REPEAT_MS   = 100;

   function automatic int ms_to_cycles(input int ms);
      return ms * CYCLES_PER_MS;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_timer.sv
// rtl/btn_timer.sv - clear/enable up-counter with terminal-count compare
module btn_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic [W-1:0] i_term,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;

   // Compare is independent of i_en so the caller can gate on it without a loop.
   assign o_tc = (r_cnt == i_term);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         if (o_tc) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/btn_events_n.sv
// rtl/btn_events_n.sv - turns a debounced active-low button level into press/release/long/repeat pulses
module btn_events_n
   import btn_events_n_pkg::*;
#(
   parameter int LONG_CNT   = ms_to_cycles(DEF_LONG_MS),
   parameter int REPEAT_CNT = ms_to_cycles(DEF_REPEAT_MS),
   parameter bit REPEAT_EN  = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic held,
   output logic press,
   output logic release_p,
   output logic long_press,
   output logic rpt
);

   localparam int CNT_MAX = max2(LONG_CNT, REPEAT_CNT);
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   state_t           r_state;
   state_t           w_next_state;
   logic             r_btn_q;
   logic             w_clr;
   logic             w_en;
   logic             w_tc;
   logic [CNT_W-1:0] w_term;
   logic             w_press;
   logic             w_release;
   logic             w_long;
   logic             w_rpt;

   // One counter serves both phases; terminal value follows the state.
   assign w_term = (r_state == ST_PRESSED) ? CNT_W'(LONG_CNT - 1) : CNT_W'(REPEAT_CNT - 1);

   btn_timer #(
      .W (CNT_W)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_clr),
      .i_en   (w_en),
      .i_term (w_term),
      .o_tc   (w_tc)
   );

   always_comb begin
      w_next_state = r_state;
      w_clr        = 1'b0;
      w_en         = 1'b0;
      w_press      = 1'b0;
      w_release    = 1'b0;
      w_long       = 1'b0;
      w_rpt        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_clr = 1'b1;
            if (r_btn_q && !btn_n) begin
               w_press      = 1'b1;
               w_next_state = ST_PRESSED;
            end
         end
         ST_PRESSED: begin
            if (btn_n) begin
               w_release    = 1'b1;
               w_clr        = 1'b1;
               w_next_state = ST_IDLE;
            end else begin
               w_en = 1'b1;
               if (w_tc) begin
                  w_long       = 1'b1;
                  w_next_state = ST_LONG;
               end
            end
         end
         ST_LONG: begin
            // Release wins over a coincident repeat tick.
            if (btn_n) begin
               w_release    = 1'b1;
               w_clr        = 1'b1;
               w_next_state = ST_IDLE;
            end else if (REPEAT_EN) begin
               w_en  = 1'b1;
               w_rpt = w_tc;
            end
         end
         default: begin
            w_clr        = 1'b1;
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_btn_q    <= 1'b1;
         held       <= 1'b0;
         press      <= 1'b0;
         release_p  <= 1'b0;
         long_press <= 1'b0;
         rpt        <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_btn_q    <= btn_n;
         held       <= (w_next_state != ST_IDLE);
         press      <= w_press;
         release_p  <= w_release;
         long_press <= w_long;
         rpt        <= w_rpt;
      end
   end

endmodule
